// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and an async-read memory (slave).
interface fetch_stage_if;

  logic [31:0] imem_a;
  logic [31:0] imem_rd;

  modport master (output imem_a, input imem_rd);
  modport slave  (input imem_a, output imem_rd);

endinterface

// File: rtl/fetch_stage_pc_gen.sv
// Program counter register with redirect / hold / increment next-PC selection.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Load beats hold so a redirect can leave a stalled pipeline.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (hold_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: boot/run/fault FSM, IF/ID register, sticky fetch fault.
// Optional range check on the fetch address is enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall_i,
  input  logic                 redirect_valid_i,
  input  logic [31:0]          redirect_pc_i,
  output logic [31:0]          if_pc_o,
  output logic [31:0]          if_pc_plus4_o,
  output logic [31:0]          if_instr_o,
  output logic                 if_valid_o,
  output logic                 fault_o,
  output logic [31:0]          fault_pc_o
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  fetch_state_t state_q, state_d;
  if_id_t       ifid_q, ifid_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  pc_q;
  logic         pc_hold, pc_load;
  logic         out_of_range;

  fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_i    (pc_hold),
    .load_i    (pc_load),
    .load_pc_i (redirect_pc_i),
    .pc_o      (pc_q)
  );

  assign out_of_range = {2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS);

  always_comb begin
    state_d    = state_q;
    ifid_d     = ifid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    pc_hold    = 1'b1;
    pc_load    = 1'b0;

    case (state_q)
      BOOT, RUN: begin
        if (state_q == BOOT) begin
          state_d = RUN;
        end
        if (redirect_valid_i && is_misaligned(redirect_pc_i)) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          fault_pc_d   = redirect_pc_i;
          ifid_d.valid = 1'b0;
          ifid_d.instr = RV_NOP;
        end else if (redirect_valid_i) begin
          pc_load      = 1'b1;
          ifid_d.valid = 1'b0;
          ifid_d.instr = RV_NOP;
        end else if (state_q == RUN && !stall_i) begin
          if (BOUNDS_EN && out_of_range) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_pc_d   = pc_q;
            ifid_d.valid = 1'b0;
            ifid_d.instr = RV_NOP;
          end else begin
            ifid_d.pc       = pc_q;
            ifid_d.pc_plus4 = pc_q + 32'd4;
            ifid_d.instr    = imem.imem_rd;
            ifid_d.valid    = 1'b1;
            pc_hold         = 1'b0;
          end
        end
      end
      default: begin
        // FAULT is terminal; everything holds until reset.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      ifid_q     <= '{pc: 32'd0, pc_plus4: 32'd0, instr: RV_NOP, valid: 1'b0};
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      ifid_q     <= ifid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign imem.imem_a   = pc_q;
  assign if_pc_o       = ifid_q.pc;
  assign if_pc_plus4_o = ifid_q.pc_plus4;
  assign if_instr_o    = ifid_q.instr;
  assign if_valid_o    = ifid_q.valid;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;

endmodule
